// File: rtl/prt_pkg.sv
// prt_pkg: shared types and constants for the packet reference table (PRT)
// slot manager. Holds the per-slot state encoding, a one-bit boolean
// typedef and the default number of slots.
package prt_pkg;

   localparam int PRT_NUM_SLOTS = 4;

   typedef logic BOOL;

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      WRITING = 2'd1,
      VALID   = 2'd2,
      READING = 2'd3
   } SlotState;

endpackage

// File: rtl/prt_free_finder.sv
// prt_free_finder: combinational lowest-index priority encoder over the
// FREE-slot bitmap.
// Ports:
//   free_map - one bit per slot, 1 = slot is FREE
//   found    - at least one bit of free_map is set
//   idx      - index of the lowest set bit (0 when found = 0)
module prt_free_finder
   import prt_pkg::*;
#(
   parameter  int NUM_SLOTS = PRT_NUM_SLOTS,
   localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
   input  logic [NUM_SLOTS-1:0] free_map,
   output BOOL                  found,
   output logic [SLOT_W-1:0]    idx
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (free_map[i]) begin
            found = 1'b1;
            idx   = SLOT_W'(i);
         end
      end
   end

endmodule

// File: rtl/prt_slot_manager.sv
// prt_slot_manager: owns the PRT slot-state table. Grants free slots to the
// rx path and tracks each slot through write, verdict wait, read and release,
// resolving same-cycle allocate / write-done / read-start / read-done /
// invalidate events.
// Ports:
//   clk, rst                         - clock, async active-low reset
//   alloc_req / alloc_gnt, alloc_slot - slot request and registered grant
//   wr_done, wr_done_slot            - rx finished writing a slot
//   rd_start, rd_start_slot          - tx wants to read a slot
//   rd_start_ack                     - registered read-start acceptance
//   rd_done, rd_done_slot            - tx finished reading a slot
//   inval, inval_slot                - firewall drops a slot
//   slot_free, free_count            - registered free-slot status
//   err                              - registered pulse, illegal event seen
//
// Per-slot states:
//   state   | meaning
//   FREE    | available for allocation
//   WRITING | granted to rx, frame being written
//   VALID   | written, waiting for verdict / read start
//   READING | tx reading; inval_pend marks a deferred drop
module prt_slot_manager
   import prt_pkg::*;
#(
   parameter  int NUM_SLOTS = PRT_NUM_SLOTS,
   localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_req,
   output logic              alloc_gnt,
   output logic [SLOT_W-1:0] alloc_slot,
   input  logic              wr_done,
   input  logic [SLOT_W-1:0] wr_done_slot,
   input  logic              rd_start,
   input  logic [SLOT_W-1:0] rd_start_slot,
   output logic              rd_start_ack,
   input  logic              rd_done,
   input  logic [SLOT_W-1:0] rd_done_slot,
   input  logic              inval,
   input  logic [SLOT_W-1:0] inval_slot,
   output logic              slot_free,
   output logic [SLOT_W:0]   free_count,
   output logic              err
);

   SlotState             state_q   [NUM_SLOTS];
   SlotState             state_nxt [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] pend_q, pend_nxt;
   logic [NUM_SLOTS-1:0] free_map;
   logic [NUM_SLOTS-1:0] hit_wd, hit_rs, hit_rd, hit_inv, hit_al;
   logic [NUM_SLOTS-1:0] wd_eff, rs_eff;
   BOOL                  free_found;
   logic [SLOT_W-1:0]    free_idx;
   logic                 ack_nxt, err_nxt;
   logic [SLOT_W:0]      cnt_nxt;

   // Allocation looks only at registered state, so a slot released this
   // cycle becomes grantable on the next one.
   always_comb begin
      free_map = '0;
      for (int i = 0; i < NUM_SLOTS; i++) free_map[i] = (state_q[i] == FREE);
   end

   prt_free_finder #(.NUM_SLOTS(NUM_SLOTS)) u_free_finder (
      .free_map (free_map),
      .found    (free_found),
      .idx      (free_idx)
   );

   always_comb begin
      hit_wd  = '0;
      hit_rs  = '0;
      hit_rd  = '0;
      hit_inv = '0;
      hit_al  = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         hit_wd[i]  = wr_done  && (wr_done_slot  == SLOT_W'(i));
         hit_rs[i]  = rd_start && (rd_start_slot == SLOT_W'(i));
         hit_rd[i]  = rd_done  && (rd_done_slot  == SLOT_W'(i));
         hit_inv[i] = inval    && (inval_slot    == SLOT_W'(i));
         hit_al[i]  = alloc_req && free_found && (free_idx == SLOT_W'(i));
      end
   end

   // An invalidate on the same slot swallows write-done and read-start
   // silently: they neither take effect nor count as errors.
   assign wd_eff = hit_wd & ~hit_inv;
   assign rs_eff = hit_rs & ~hit_inv;

   always_comb begin
      ack_nxt = 1'b0;
      err_nxt = 1'b0;
      cnt_nxt = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         state_nxt[i] = state_q[i];
         pend_nxt[i]  = pend_q[i];
         case (state_q[i])
            FREE: begin
               if (hit_al[i]) state_nxt[i] = WRITING;
               if (hit_wd[i] || hit_rs[i] || hit_rd[i] || hit_inv[i]) err_nxt = 1'b1;
            end
            WRITING: begin
               if (hit_inv[i])     state_nxt[i] = FREE;
               else if (hit_wd[i]) state_nxt[i] = VALID;
               if (rs_eff[i] || hit_rd[i]) err_nxt = 1'b1;
            end
            VALID: begin
               if (hit_inv[i]) begin
                  state_nxt[i] = FREE;
               end else if (hit_rs[i]) begin
                  state_nxt[i] = READING;
                  ack_nxt      = 1'b1;
               end
               if (wd_eff[i] || hit_rd[i]) err_nxt = 1'b1;
            end
            READING: begin
               // A frame in transmission is never cut: inval only defers.
               if (hit_rd[i]) begin
                  state_nxt[i] = FREE;
                  pend_nxt[i]  = 1'b0;
               end else if (hit_inv[i]) begin
                  pend_nxt[i]  = 1'b1;
               end
               if (wd_eff[i] || rs_eff[i]) err_nxt = 1'b1;
            end
            default: state_nxt[i] = FREE;
         endcase
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (state_nxt[i] == FREE) cnt_nxt = cnt_nxt + (SLOT_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) state_q[i] <= FREE;
         pend_q       <= '0;
         alloc_gnt    <= 1'b0;
         alloc_slot   <= '0;
         rd_start_ack <= 1'b0;
         err          <= 1'b0;
         slot_free    <= 1'b1;
         free_count   <= (SLOT_W+1)'(NUM_SLOTS);
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) state_q[i] <= state_nxt[i];
         pend_q       <= pend_nxt;
         alloc_gnt    <= alloc_req && free_found;
         if (alloc_req && free_found) alloc_slot <= free_idx;
         rd_start_ack <= ack_nxt;
         err          <= err_nxt;
         slot_free    <= (cnt_nxt != '0);
         free_count   <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_prt_slot_manager.sv
module tb_prt_slot_manager;

   localparam int NS = 4;
   localparam int M_FREE = 0, M_WRITE = 1, M_VALID = 2, M_READ = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       alloc_req = 1'b0;
   logic       alloc_gnt;
   logic [1:0] alloc_slot;
   logic       wr_done = 1'b0;
   logic [1:0] wr_done_slot = '0;
   logic       rd_start = 1'b0;
   logic [1:0] rd_start_slot = '0;
   logic       rd_start_ack;
   logic       rd_done = 1'b0;
   logic [1:0] rd_done_slot = '0;
   logic       inval = 1'b0;
   logic [1:0] inval_slot = '0;
   logic       slot_free;
   logic [2:0] free_count;
   logic       err;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: slot lifecycle as plain integers
   int m_state [NS];
   int e_gnt, e_slot, e_ack, e_err, e_cnt;

   prt_slot_manager #(.NUM_SLOTS(NS)) dut (
      .clk           (clk),
      .rst           (rst),
      .alloc_req     (alloc_req),
      .alloc_gnt     (alloc_gnt),
      .alloc_slot    (alloc_slot),
      .wr_done       (wr_done),
      .wr_done_slot  (wr_done_slot),
      .rd_start      (rd_start),
      .rd_start_slot (rd_start_slot),
      .rd_start_ack  (rd_start_ack),
      .rd_done       (rd_done),
      .rd_done_slot  (rd_done_slot),
      .inval         (inval),
      .inval_slot    (inval_slot),
      .slot_free     (slot_free),
      .free_count    (free_count),
      .err           (err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < NS; k++) m_state[k] = M_FREE;
      e_gnt = 0; e_slot = 0; e_ack = 0; e_err = 0; e_cnt = NS;
   endfunction

   // Apply one clock edge's worth of events to the model, each judged on the
   // pre-edge state of its target slot.
   function automatic void model_step();
      int nxt [NS];
      int k;
      for (int j = 0; j < NS; j++) nxt[j] = m_state[j];
      e_gnt = 0; e_ack = 0; e_err = 0;
      if (rd_done) begin
         k = int'(rd_done_slot);
         if (m_state[k] == M_READ) nxt[k] = M_FREE;
         else e_err = 1;
      end
      if (inval) begin
         k = int'(inval_slot);
         if (rd_done && rd_done_slot == inval_slot && m_state[k] == M_READ) ;
         else if (m_state[k] == M_FREE) e_err = 1;
         else if (m_state[k] != M_READ) nxt[k] = M_FREE;
      end
      if (wr_done && !(inval && inval_slot == wr_done_slot)) begin
         k = int'(wr_done_slot);
         if (m_state[k] == M_WRITE) nxt[k] = M_VALID;
         else e_err = 1;
      end
      if (rd_start && !(inval && inval_slot == rd_start_slot)) begin
         k = int'(rd_start_slot);
         if (m_state[k] == M_VALID) begin
            nxt[k] = M_READ;
            e_ack = 1;
         end else e_err = 1;
      end
      if (alloc_req) begin
         for (int j = NS - 1; j >= 0; j--) begin
            if (m_state[j] == M_FREE) begin
               e_gnt = 1;
               e_slot = j;
            end
         end
         if (e_gnt == 1) nxt[e_slot] = M_WRITE;
      end
      e_cnt = 0;
      for (int j = 0; j < NS; j++) begin
         m_state[j] = nxt[j];
         if (nxt[j] == M_FREE) e_cnt++;
      end
   endfunction

   task automatic check_outputs();
      check_val("alloc_gnt", int'(alloc_gnt), e_gnt);
      if (e_gnt == 1) check_val("alloc_slot", int'(alloc_slot), e_slot);
      check_val("rd_start_ack", int'(rd_start_ack), e_ack);
      check_val("err", int'(err), e_err);
      check_val("slot_free", int'(slot_free), int'(e_cnt != 0));
      check_val("free_count", int'(free_count), e_cnt);
   endtask

   task automatic step(input logic a,
                       input logic w, input logic [1:0] ws,
                       input logic s, input logic [1:0] ss,
                       input logic d, input logic [1:0] ds,
                       input logic v, input logic [1:0] vs);
      @(negedge clk);
      alloc_req = a;
      wr_done = w;  wr_done_slot = ws;
      rd_start = s; rd_start_slot = ss;
      rd_done = d;  rd_done_slot = ds;
      inval = v;    inval_slot = vs;
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
   endtask

   task automatic idle(input logic a);
      step(a, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      alloc_req = 1'b0; wr_done = 1'b0; rd_start = 1'b0; rd_done = 1'b0; inval = 1'b0;
      rst = 1'b0;
      #1;
      model_reset();
      check_val("rst_gnt", int'(alloc_gnt), 0);
      check_val("rst_slot", int'(alloc_slot), 0);
      check_val("rst_ack", int'(rd_start_ack), 0);
      check_val("rst_err", int'(err), 0);
      check_val("rst_free", int'(slot_free), 1);
      check_val("rst_cnt", int'(free_count), NS);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      do_reset();

      // fill every slot; fifth request gets nothing
      for (int i = 0; i < 5; i++) idle(1'b1);
      check_val("full_cnt", int'(free_count), 0);
      idle(1'b0);

      // slot 1: write, read, release, regrant
      step(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
      step(1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0);
      step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0);
      check_val("s1_released_cnt", int'(free_count), 1);
      idle(1'b1);
      check_val("s1_regrant", int'(alloc_slot), 1);

      // slot 2: inval while reading is deferred until rd_done
      step(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
      step(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0);
      step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2);
      check_val("s2_inval_reading_err", int'(err), 0);
      check_val("s2_still_busy_cnt", int'(free_count), 0);
      step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0);
      check_val("s2_freed_cnt", int'(free_count), 1);

      // same-slot conflicts: inval+wr_done on 0, inval+rd_start on 3
      step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0);
      check_val("s0_conflict_err", int'(err), 0);
      step(1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
      step(1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b1, 2'd3);
      check_val("s3_conflict_ack", int'(rd_start_ack), 0);
      check_val("s3_conflict_err", int'(err), 0);

      // release in cycle N while alloc_req held: grant lands at N+2
      do_reset();
      for (int i = 0; i < 4; i++) idle(1'b1);
      step(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
      step(1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0);
      step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0);
      check_val("relN_gnt", int'(alloc_gnt), 0);
      idle(1'b1);
      check_val("relN2_gnt", int'(alloc_gnt), 1);
      check_val("relN2_slot", int'(alloc_slot), 2);

      // wr_done on a FREE slot: single-cycle err pulse
      do_reset();
      step(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
      check_val("free_wd_err", int'(err), 1);
      idle(1'b0);
      check_val("free_wd_err_drop", int'(err), 0);

      // reset mid-read
      idle(1'b1);
      step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
      step(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
      do_reset();

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step(logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)),
              logic'($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)),
              logic'($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)),
              logic'($urandom_range(0, 9) < 2), 2'($urandom_range(0, 3)));
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
